fft8_frame_loader: RTL

//   Upstream feeder for fft8. Collects a serial complex sample stream (bearing vibration
//   ADC data) into a sliding 8-sample window and presents it as one parallel frame with a
//   one-cycle en strobe. Frames are emitted every HOP accepted samples, so consecutive

---
 rtl/fft8_frame_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: upstream feeder for fft8. Collects a serial complex sample stream into
// a sliding 8-sample window. Every HOP accepted samples it emits the window as one parallel
// frame together with a one-cycle o_en strobe. Lane 0 holds the oldest sample.
//
// Build option FFT8_FRAME_WINDOW_EN: when defined, a periodic 8-point Hann window (Q1.15)
// is applied to the real and imag lanes. This adds one pipeline register, so the frame
// latency is 2 cycles instead of 1. When undefined, the lanes pass through bit-exact.
module fft8_frame_loader #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned HOP    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_real,
    input  logic [DATA_W-1:0]     s_imag,
    output logic                  o_en,
    output logic [8*DATA_W-1:0]   frame_real,
    output logic [8*DATA_W-1:0]   frame_imag,
    output logic [15:0]           frame_cnt,
    output logic                  primed
);

    // Reject an illegal hop length at elaboration.
    if (HOP == 0 || HOP > 8) begin : g_hop_check
        $error("fft8_frame_loader: HOP must be in the range 1..8");
    end

    localparam logic [2:0] HopLast = 3'(HOP - 1);

    typedef enum logic [0:0] {
        StFill,
        StRun
    } state_e;

    state_e             state_q;
    logic [3:0]         fill_cnt_q;
    logic [2:0]         hop_cnt_q;

    // Oldest sample of the window (sr[0]) is dropped at the same edge the window is
    // captured, so only the newest seven samples (sr[1..7]) need storage.
    logic [DATA_W-1:0]  hist_real_q [7];
    logic [DATA_W-1:0]  hist_imag_q [7];

    logic               accept;
    logic               emit;
    logic [DATA_W-1:0]  win_real [8];
    logic [DATA_W-1:0]  win_imag [8];

    // Post-shift window (including the incoming sample) and the emit decision.
    always_comb begin
        accept = s_valid && !flush;
        for (int k = 0; k < 7; k++) begin
            win_real[k] = hist_real_q[k];
            win_imag[k] = hist_imag_q[k];
        end
        win_real[7] = s_real;
        win_imag[7] = s_imag;
        emit = 1'b0;
        if (accept) begin
            if (state_q == StFill) begin
                emit = (fill_cnt_q == 4'd7);
            end else begin
                emit = (hop_cnt_q == HopLast);
            end
        end
    end

    // Shift register: each accepted sample enters at the newest end.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) begin
                hist_real_q[k] <= '0;
                hist_imag_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < 7; k++) begin
                hist_real_q[k] <= win_real[k + 1];
                hist_imag_q[k] <= win_imag[k + 1];
            end
        end
    end

    // Fill/run sequencing: count the initial fill, then count hops between frames.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // Stale shift-register contents are refilled before the next emit.
            state_q    <= StFill;
            fill_cnt_q <= '0;
            hop_cnt_q  <= '0;
            primed     <= 1'b0;
        end else if (accept) begin
            unique case (state_q)
                StFill: begin
                    fill_cnt_q <= fill_cnt_q + 4'd1;
                    if (fill_cnt_q == 4'd7) begin
                        state_q   <= StRun;
                        hop_cnt_q <= '0;
                        primed    <= 1'b1;
                    end
                end
                StRun: begin
                    hop_cnt_q <= (hop_cnt_q == HopLast) ? 3'd0 : hop_cnt_q + 3'd1;
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

`ifdef FFT8_FRAME_WINDOW_EN

    // Periodic Hann window, Q1.15, lane 0..7.
    localparam logic [15:0] HannCoef [8] = '{
        16'd0, 16'd4799, 16'd16384, 16'd27969, 16'd32767, 16'd27969, 16'd16384, 16'd4799
    };

    // Round-half-up Q1.15 scaling; |w| < 1 so the result always fits back in DATA_W.
    function automatic logic [DATA_W-1:0] apply_window(input logic [DATA_W-1:0] x,
                                                       input logic [15:0]       w);
        logic signed [DATA_W+15:0] prod;
        logic signed [DATA_W+15:0] rounded;
        logic signed [DATA_W+15:0] scaled;
        prod    = (DATA_W+16)'($signed(x)) * (DATA_W+16)'($signed(w));
        rounded = prod + (DATA_W+16)'(16384);
        scaled  = rounded >>> 15;
        return scaled[DATA_W-1:0];
    endfunction

    logic               stage_en_q;
    logic [DATA_W-1:0]  stage_real_q [8];
    logic [DATA_W-1:0]  stage_imag_q [8];
    logic [DATA_W-1:0]  wnd_real [8];
    logic [DATA_W-1:0]  wnd_imag [8];

    // Windowed lanes computed from the captured raw frame.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            wnd_real[k] = apply_window(stage_real_q[k], HannCoef[k]);
            wnd_imag[k] = apply_window(stage_imag_q[k], HannCoef[k]);
        end
    end

    // Two-stage output: capture raw window, then register windowed lanes with o_en.
    // Flush does not touch this pipeline, so an in-flight frame still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_en_q <= 1'b0;
            o_en       <= 1'b0;
            frame_real <= '0;
            frame_imag <= '0;
            frame_cnt  <= '0;
            for (int k = 0; k < 8; k++) begin
                stage_real_q[k] <= '0;
                stage_imag_q[k] <= '0;
            end
        end else begin
            stage_en_q <= emit;
            if (emit) begin
                for (int k = 0; k < 8; k++) begin
                    stage_real_q[k] <= win_real[k];
                    stage_imag_q[k] <= win_imag[k];
                end
            end
            o_en <= stage_en_q;
            if (stage_en_q) begin
                for (int k = 0; k < 8; k++) begin
                    frame_real[k*DATA_W +: DATA_W] <= wnd_real[k];
                    frame_imag[k*DATA_W +: DATA_W] <= wnd_imag[k];
                end
            end
            // A flush restarts the count even if a pre-flush frame is still draining.
            if (flush) begin
                frame_cnt <= '0;
            end else if (stage_en_q) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`else

    // Single output stage: frame lanes load the post-shift window on each emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_en       <= 1'b0;
            frame_real <= '0;
            frame_imag <= '0;
            frame_cnt  <= '0;
        end else begin
            o_en <= emit;
            if (emit) begin
                for (int k = 0; k < 8; k++) begin
                    frame_real[k*DATA_W +: DATA_W] <= win_real[k];
                    frame_imag[k*DATA_W +: DATA_W] <= win_imag[k];
                end
            end
            if (flush) begin
                frame_cnt <= '0;
            end else if (emit) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`endif

endmodule
